// File: rtl/fifo_rr_sched.sv
// Round-robin drain scheduler over NQ fifo1 queues with a registered valid/ready output stage.
// Optional FIFO_RR_SCHED_STATS_EN adds a saturating backpressure stall counter (stall_cnt).
module fifo_rr_sched #(
  parameter int WIDTH = 8,
  parameter int NQ    = 4,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NQ-1:0]         q_empty,
  input  logic [NQ*WIDTH-1:0]   q_data,
  output logic [NQ-1:0]         q_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [$clog2(NQ)-1:0] out_qid
`ifdef FIFO_RR_SCHED_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int QW = $clog2(NQ);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t         state;
  logic [QW-1:0]  grant;
  logic [QW-1:0]  ptr;
  logic [BW-1:0]  bcnt;
  logic           popped;

  logic           can_out;
  logic           pop_ok;
  logic           leave;
  logic [QW-1:0]  pick;
  logic [QW-1:0]  grant_nxt;
  logic [WIDTH-1:0] head;

  assign can_out   = !out_valid || out_ready;
  assign pop_ok    = (state == SERVE) && enable && !q_empty[grant] && can_out;
  assign leave     = !enable || (q_empty[grant] && can_out) ||
                     (pop_ok && (bcnt == BW'(BURST - 1)));
  assign grant_nxt = (grant == QW'(NQ - 1)) ? '0 : grant + 1'b1;
  assign head      = q_data[grant*WIDTH +: WIDTH];

  // First non-empty queue scanning from ptr, wrapping modulo NQ.
  always_comb begin
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NQ; i++) begin
      int unsigned idx;
      idx = (int'(ptr) + i) % NQ;
      if (!found && !q_empty[idx]) begin
        pick  = QW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    q_pop = '0;
    if (pop_ok) q_pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      bcnt      <= '0;
      popped    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_qid   <= '0;
    end else begin
      if (pop_ok) begin
        out_data  <= head;
        out_qid   <= grant;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable && !(&q_empty)) begin
            grant  <= pick;
            bcnt   <= '0;
            popped <= 1'b0;
            state  <= SERVE;
          end
        end
        SERVE: begin
          if (pop_ok) begin
            bcnt   <= bcnt + 1'b1;
            popped <= 1'b1;
          end
          // The pop in the leaving cycle counts toward advancing the pointer.
          if (leave) begin
            state <= IDLE;
            if (popped || pop_ok) ptr <= grant_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: cycle table for a single-queue drain plus multi-cycle scenarios.
module tb_fifo_rr_sched;
  localparam int WIDTH = 8;
  localparam int NQ    = 4;
  localparam int BURST = 4;
  localparam int QW    = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                out_ready;
  logic [NQ-1:0]       q_empty;
  logic [NQ-1:0]       q_pop;
  logic [NQ*WIDTH-1:0] q_data;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic [QW-1:0]       out_qid;
`ifdef FIFO_RR_SCHED_STATS_EN
  logic [15:0]         stall_cnt;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int npop = 0;

  logic [7:0] mem [NQ][256];
  logic [7:0] rd [NQ];
  logic [7:0] wr [NQ];
  int log_d[$];
  int log_id[$];
  int log_t[$];

  typedef struct {
    logic       en;
    logic       rdy;
    logic [3:0] pop;
    logic       vld;
    logic [7:0] data;
    logic [1:0] qid;
  } vec_t;

  always #5 clk = ~clk;

  fifo_rr_sched #(.WIDTH(WIDTH), .NQ(NQ), .BURST(BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .q_empty  (q_empty),
    .q_data   (q_data),
    .q_pop    (q_pop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_qid  (out_qid)
`ifdef FIFO_RR_SCHED_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Queue models: head word and empty flag; pops retire on the clock edge.
  always_comb begin
    q_data  = '0;
    q_empty = '1;
    for (int i = 0; i < NQ; i++) begin
      q_data[i*WIDTH +: WIDTH] = mem[i][rd[i]];
      q_empty[i] = (rd[i] == wr[i]);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NQ; i++)
      if (q_pop[i]) rd[i] <= rd[i] + 8'd1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        log_d.push_back(int'(out_data));
        log_id.push_back(int'(out_qid));
        log_t.push_back(cyc);
      end
      if (q_pop != '0) begin
        npop++;
        nvec++;
        if (((q_pop & q_empty) != '0) || !$onehot(q_pop)) begin
          nerr++;
          $display("FAIL pop_legal: q_pop=%b q_empty=%b", q_pop, q_empty);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int q, input logic [7:0] val);
    mem[q][wr[q]] = val;
    wr[q] = wr[q] + 8'd1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NQ; i++) wr[i] = rd[i];
    log_d.delete();
    log_id.delete();
    log_t.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_log", log_d.size(), n);
  endtask

  initial begin
    vec_t tbl[6];
    int   exp_d[$];
    int   exp_id[$];

    tbl[0] = '{1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[3] = '{1'b1, 1'b1, 4'b0010, 1'b1, 8'hA2, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 4'b0000, 1'b1, 8'hA3, 2'd1};
    tbl[5] = '{1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    for (int i = 0; i < NQ; i++) begin
      rd[i] = 8'd0;
      wr[i] = 8'd0;
    end

    // Reset values and single-queue drain
    do_reset();
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_qid", out_qid, 0);
    check("rst_pop", q_pop, 0);
    tick();
    load(1, 8'hA1);
    load(1, 8'hA2);
    load(1, 8'hA3);
    for (int i = 0; i < 6; i++) begin
      enable    = tbl[i].en;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_pop", i), q_pop, tbl[i].pop);
      check($sformatf("v%0d_valid", i), out_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        check($sformatf("v%0d_data", i), out_data, tbl[i].data);
        check($sformatf("v%0d_qid", i), out_qid, tbl[i].qid);
      end
      tick();
    end

    // Fairness: 6 words in every queue, bursts of 4 then 2
    do_reset();
    enable = 1'b1;
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 6; k++) load(q, 8'(q * 16 + k));
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 4; k++) begin exp_id.push_back(q); exp_d.push_back(q * 16 + k); end
    for (int q = 0; q < NQ; q++)
      for (int k = 4; k < 6; k++) begin exp_id.push_back(q); exp_d.push_back(q * 16 + k); end
    wait_log(24, 200);
    for (int i = 0; i < 24 && i < log_d.size(); i++) begin
      check($sformatf("fair%0d_qid", i), log_id[i], exp_id[i]);
      check($sformatf("fair%0d_data", i), log_d[i], exp_d[i]);
    end
    if (log_t.size() >= 5) begin
      check("fair_back2back", log_t[1] - log_t[0], 1);
      check("fair_bubble", log_t[4] - log_t[3], 2);
    end

    // Backpressure mid-burst for 5 cycles
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) load(0, 8'(8'hB0 + k));
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_pop", q_pop, 0);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'hB1);
      tick();
    end
    out_ready = 1'b1;
    wait_log(4, 20);
    for (int i = 0; i < 4 && i < log_d.size(); i++)
      check($sformatf("bp_word%0d", i), log_d[i], 8'hB0 + i);
`ifdef FIFO_RR_SCHED_STATS_EN
    check("stall_cnt", stall_cnt, 5);
`endif
    repeat (3) tick();
    check("bp_no_dup", log_d.size(), 4);

    // Enable low: queues loaded but nothing may pop
    do_reset();
    for (int q = 0; q < NQ; q++) load(q, 8'(8'hE0 + q));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("dis_pop", q_pop, 0);
      tick();
    end
    check("dis_log", log_d.size(), 0);

    // Enable dropped after 2 pops, then re-enable rotates to grant+1
    do_reset();
    for (int k = 0; k < 6; k++) load(1, 8'(8'h60 + k));
    load(2, 8'h70);
    load(2, 8'h71);
    enable = 1'b1;
    npop   = 0;
    tick();
    tick();
    tick();
    enable = 1'b0;
    repeat (6) tick();
    check("en_pops", npop, 2);
    check("en_log", log_d.size(), 2);
    if (log_d.size() >= 2) begin
      check("en_w0", log_d[0], 8'h60);
      check("en_w1", log_d[1], 8'h61);
    end
    enable = 1'b1;
    wait_log(3, 20);
    if (log_d.size() >= 3) begin
      check("reen_qid", log_id[2], 2);
      check("reen_data", log_d[2], 8'h70);
    end

    // Queue runs dry: q2 one word, q3 three words
    do_reset();
    enable = 1'b1;
    load(2, 8'hC0);
    load(3, 8'hD0);
    load(3, 8'hD1);
    load(3, 8'hD2);
    wait_log(4, 30);
    exp_d  = '{8'hC0, 8'hD0, 8'hD1, 8'hD2};
    exp_id = '{2, 3, 3, 3};
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      check($sformatf("dry%0d_qid", i), log_id[i], exp_id[i]);
      check($sformatf("dry%0d_data", i), log_d[i], exp_d[i]);
    end

    // Reset mid-burst, then first grant must go to queue 0
    do_reset();
    enable = 1'b1;
    load(0, 8'h01);
    for (int k = 0; k < 8; k++) load(1, 8'(8'h10 + k));
    repeat (7) tick();
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_qid", out_qid, 0);
    check("mid_rst_pop", q_pop, 0);
    log_d.delete();
    log_id.delete();
    log_t.delete();
    load(0, 8'h55);
    tick();
    tick();
    rst_n = 1'b1;
    wait_log(1, 20);
    if (log_d.size() >= 1) begin
      check("post_rst_qid", log_id[0], 0);
      check("post_rst_data", log_d[0], 8'h55);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
